// File: rtl/mem_bipo_rd_ctrl_pkg.sv
// Shared definitions for the prediction-buffer read and write controllers.
// Holds the block size codes, the coordinate/index widths and the helpers
// that map a block size to its read count and line-index step.
package mem_bipo_rd_ctrl_pkg;

  localparam int unsigned IDX_W = 5;  // line index within a block (32 reads max)
  localparam int unsigned POS_W = 4;  // x/y coordinate in 4x4 units
  localparam int unsigned NUM_W = 6;  // holds a read count up to 32

  // Block size codes (enc_defines-compatible)
  localparam logic [1:0] I_4x4   = 2'b00;
  localparam logic [1:0] I_8x8   = 2'b01;
  localparam logic [1:0] I_16x16 = 2'b10;
  localparam logic [1:0] I_32x32 = 2'b11;

  // Number of 32-pixel buffer reads needed for one block
  function automatic logic [NUM_W-1:0] num_reads(input logic [1:0] size);
    case (size)
      I_4x4:   num_reads = NUM_W'(1);
      I_8x8:   num_reads = NUM_W'(2);
      I_16x16: num_reads = NUM_W'(8);
      default: num_reads = NUM_W'(32);
    endcase
  endfunction

  // Left shift turning the read counter into a buffer line index
  function automatic logic [1:0] idx_shift(input logic [1:0] size);
    case (size)
      I_8x8:   idx_shift = 2'd2;
      I_16x16: idx_shift = 2'd1;
      default: idx_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bipo_rd_ctrl_if.sv
// Command/read-port bundle of the prediction-buffer read sequencer.
//   master : consumer side (drives start/size/x/y/out_rdy, sees status/read port)
//   slave  : sequencer side
// Signals:
//   start_i, size_i, x_i, y_i   block read command
//   out_rdy_i                   consumer accepts a word one cycle after ren_o
//   busy_o                      block in progress
//   ren_o, rsize_o, r4x4_x_o, r4x4_y_o, ridx_o   buffer read command
//   rvalid_o, rlast_o, done_o   read data qualifiers, aligned with buffer rdata
interface mem_bipo_rd_ctrl_if;
  import mem_bipo_rd_ctrl_pkg::*;

  logic             start_i;
  logic [1:0]       size_i;
  logic [POS_W-1:0] x_i;
  logic [POS_W-1:0] y_i;
  logic             out_rdy_i;
  logic             busy_o;
  logic             ren_o;
  logic [1:0]       rsize_o;
  logic [POS_W-1:0] r4x4_x_o;
  logic [POS_W-1:0] r4x4_y_o;
  logic [IDX_W-1:0] ridx_o;
  logic             rvalid_o;
  logic             rlast_o;
  logic             done_o;

  modport master (
    output start_i, size_i, x_i, y_i, out_rdy_i,
    input  busy_o, ren_o, rsize_o, r4x4_x_o, r4x4_y_o, ridx_o,
           rvalid_o, rlast_o, done_o
  );

  modport slave (
    input  start_i, size_i, x_i, y_i, out_rdy_i,
    output busy_o, ren_o, rsize_o, r4x4_x_o, r4x4_y_o, ridx_o,
           rvalid_o, rlast_o, done_o
  );

endinterface

// File: rtl/mem_bipo_rd_ctrl.sv
// Read sequencer for the 4x4-block-in / parallel-line-out prediction buffer.
// On start it issues every buffer read for one square block (4x4..32x32),
// stalling on consumer backpressure, and produces rvalid/rlast/done one
// cycle later, aligned with the buffer read data.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  command/read-port bundle (slave side)
module mem_bipo_rd_ctrl
  import mem_bipo_rd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_bipo_rd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_LAST = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [1:0]       size_q, size_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;

  logic             ren_c;
  logic             last_rd_c;

  // A read goes out only while sequencing and the consumer promises to take it
  assign ren_c     = (state_q == S_RD) && bus.out_rdy_i;
  assign last_rd_c = (cnt_q == IDX_W'(num_reads(size_q) - NUM_W'(1)));

  // State, counter, latched command and output pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      size_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  // Next-state, counter and command-latch logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    x_d      = x_q;
    y_d      = y_q;
    rvalid_d = ren_c;                // one-cycle buffer read latency
    rlast_d  = ren_c && last_rd_c;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          size_d  = bus.size_i;
          x_d     = bus.x_i;
          y_d     = bus.y_i;
          cnt_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (ren_c) begin
          if (last_rd_c) begin
            state_d = S_LAST;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_LAST: begin
        // final word is on the buffer output this cycle; start is ignored
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.ren_o    = ren_c;
  assign bus.rsize_o  = size_q;
  assign bus.r4x4_x_o = x_q;
  assign bus.r4x4_y_o = y_q;
  // 4x4 blocks fit in one line, so the index is pinned to 0
  assign bus.ridx_o   = (size_q == I_4x4) ? '0 : (cnt_q << idx_shift(size_q));
  assign bus.rvalid_o = rvalid_q;
  assign bus.rlast_o  = rlast_q;
  assign bus.done_o   = rvalid_q && rlast_q;

endmodule
